// File: rtl/newhope_io_pkg.sv
// Shared definitions for the NewHope host word-load path: state codes, default
// seed size and the byte-lane helper used by the serializer.
package newhope_io_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int unsigned SEED_WORDS = 8;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StStream = ST_STREAM,
    StDone   = ST_DONE
  } rx_state_e;

  // Lane 0 is the least significant byte, matching the host's buffer32 packing.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/word_regfile.sv
// WORDS x 32-bit register file with one synchronous write port and one
// combinational read port; contents clear on reset.
module word_regfile
  import newhope_io_pkg::*;
#(
  parameter int unsigned WORDS = SEED_WORDS,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        if (waddr == AW'(i)) begin
          mem_q[i] <= wdata;
        end
      end
    end
  end

  // Out-of-range addresses read as zero.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (raddr == AW'(i)) begin
        rdata = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/seed_word_rx.sv
// Host word-load receiver: stores 32-bit host writes and streams them LSB-byte
// first over valid/ready. Optional running XOR of streamed bytes: XOR_CHECK_EN.
module seed_word_rx
  import newhope_io_pkg::*;
#(
  parameter int unsigned WORDS = SEED_WORDS,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   dia,
  input  logic          wea,
  input  logic [AW-1:0] addra,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          wr_err,
  output logic [7:0]    out_byte,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready
`ifdef XOR_CHECK_EN
  ,
  output logic [7:0]    chk
`endif
);

  localparam int unsigned NBYTES = 4 * WORDS;
  localparam int unsigned IW     = $clog2(NBYTES);
  localparam logic [IW-1:0] LastIdx = IW'(NBYTES - 1);

  rx_state_e     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, idx_nxt;
  logic [7:0]    out_byte_q, out_byte_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          wr_err_q, wr_err_d;
  logic [7:0]    chk_q, chk_d;

  logic          wr_en;
  logic          fwd_hit;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic [31:0]   rd_word;

  assign wr_en   = wea && (state_q != StStream) && (32'(addra) < WORDS);
  assign idx_nxt = idx_q + 1'b1;
  // While streaming, prefetch the word holding the next byte; otherwise word 0.
  assign rd_addr = (state_q == StStream) ? AW'(idx_nxt[IW-1:2]) : '0;
  // A write landing on the same edge as start must show up in byte 0.
  assign fwd_hit = wr_en && (addra == rd_addr);
  assign rd_word = fwd_hit ? dia : rd_data;

  word_regfile #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (addra),
    .wdata (dia),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    wr_err_d    = wr_err_q | (wea && (state_q == StStream));
    chk_d       = chk_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StStream;
          idx_d       = '0;
          out_byte_d  = byte_lane(rd_word, 2'd0);
          out_valid_d = 1'b1;
          out_last_d  = (LastIdx == '0);
          chk_d       = '0;
        end
      end
      StStream: begin
        if (out_valid_q && out_ready) begin
          chk_d = chk_q ^ out_byte_q;
          if (out_last_q) begin
            state_d     = StDone;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            idx_d      = idx_nxt;
            out_byte_d = byte_lane(rd_word, idx_nxt[1:0]);
            out_last_d = (idx_nxt == LastIdx);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      wr_err_q    <= 1'b0;
      chk_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      wr_err_q    <= wr_err_d;
      chk_q       <= chk_d;
    end
  end

  assign busy      = (state_q == StStream);
  assign done      = (state_q == StDone);
  assign wr_err    = wr_err_q;
  assign out_byte  = out_byte_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

`ifdef XOR_CHECK_EN
  assign chk = chk_q;
`else
  logic unused_chk;
  assign unused_chk = ^chk_d;
`endif

endmodule

// File: doc/seed_word_rx.md
Name: seed_word_rx

Overview:
- Receiving end of the host word-load interface used by keygen and encrypter for seed, coin, pubseed and m.
- Accepts 32-bit host writes (dia/wea/addra) into a small register file.
- On start, serializes the stored words little-endian as a byte stream with valid/ready handshake to the NewHope core (SHAKE/Trivium absorb logic).
- Reports busy and done to the host-facing controller.

Parameters:
- WORDS, 8, number of 32-bit words stored and streamed (8 = 256-bit seed).
- AW, 4, width of host word address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- dia  in  32  host write data.
- wea  in  1  host write enable, sampled on rising clk.
- addra  in  AW  host word address.
- start  in  1  single-cycle pulse; begin streaming.
- busy  out  1  high while streaming.
- done  out  1  level; high after the last byte is accepted, until next start or rst.
- wr_err  out  1  sticky; host write attempted while busy.
- out_byte  out  8  streamed byte.
- out_valid  out  1  out_byte valid.
- out_last  out  1  high with the final byte (index 4*WORDS-1).
- out_ready  in  1  core accepts out_byte.

Behaviour:
- Reset (async, on rst high):
  - All storage words = 0.
  - State = IDLE, byte index = 0.
  - busy = 0, done = 0, wr_err = 0, out_valid = 0, out_last = 0, out_byte = 0.
- FSM states IDLE, STREAM, DONE.
  - IDLE -> STREAM on start.
  - STREAM -> DONE when out_valid & out_ready & out_last.
  - DONE -> STREAM on start; index reset to 0; done drops the cycle after start.
- Host writes:
  - With wea=1 in IDLE or DONE and addra < WORDS: mem[addra] <= dia at that edge.
  - addra >= WORDS: write ignored, no error.
  - wea=1 in STREAM: write ignored; wr_err set and held until rst.
- start handling:
  - start while in STREAM: ignored.
  - start and wea in the same IDLE/DONE cycle: the write commits; streaming begins next cycle and includes the new data.
- Streaming (byte order and timing):
  - Byte i = mem[i>>2][8*(i%4)+:8]. Byte 0 is dia[7:0] of word 0 (matches host buffer32 packing).
  - out_byte, out_valid and out_last are registered.
  - The first byte is valid the cycle after start (latency 1).
  - Index advances only on the cycle where out_valid & out_ready.
  - out_byte is held stable while out_ready = 0.
  - With out_ready held high, throughput is 1 byte/cycle and all 4*WORDS bytes leave in 4*WORDS cycles.
- End of stream:
  - out_valid deasserts the cycle after the last handshake.
  - busy = (state == STREAM). done = (state == DONE).
- Index width is clog2(4*WORDS). The index never wraps within a stream; the DONE transition occurs at the final index.
- Reset asserted mid-stream aborts immediately; no partial done.

Optional Feature:
- Macro XOR_CHECK_EN.
- Defined:
  - Adds output port chk (8 bits) = XOR of all bytes handshaken since the last start; cleared on start and rst.
  - chk is stable while done = 1.
- Undefined: port and accumulator absent; all other behaviour identical.

Decomposition:
- Shared package newhope_io_pkg holds:
  - State encoding constants (ST_IDLE=2'd0, ST_STREAM=2'd1, ST_DONE=2'd2).
  - Default SEED_WORDS=8.
  - Byte-lane select function (word, lane).
- One natural sub-module: word_regfile (WORDS x 32, one write port, one combinational read port).
- The FSM and serializer stay in seed_word_rx.

Test Plan:
- Load words 0..7 = 32'h03020100, 32'h07060504, ..., 32'h1f1e1d1c; start with out_ready=1 -> bytes 00..1f in order; out_last only on 1f; done=1 the cycle after; 32 handshakes total.
- Same load; toggle out_ready 1,0,0,1,... -> out_byte is held during stalls; the sequence is still 00..1f with no duplicates or drops.
- During STREAM, wea=1 with addra=0, dia=FFFFFFFF -> wr_err=1 sticky; streamed byte 0 remains 00; a second start after done streams 00 again.
- Write with addra=9 (>=WORDS), dia=DEADBEEF -> no storage change, wr_err stays 0.
- Assert rst after 5 bytes -> outputs zero immediately; after a new start, every byte streamed is 00 (storage cleared).
- With XOR_CHECK_EN and the 00..1f load -> chk=8'h00 at done. With word 0 = 32'h000000A5 and others 0 -> chk=8'hA5.
